// File: rtl/pc_seq_pkg.sv
// Shared definitions for the femtoRV32 fetch-stage PC sequencer.
//   pc_state_t     : sequencer FSM states
//   redirect_src_t : which source supplied the next PC (sequential, branch, jalr, trap)
//   IALIGN_*       : instruction alignment in bytes with and without the compressed extension
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HALT    = 2'd2,
    MISWAIT = 2'd3
  } pc_state_t;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JALR   = 2'd2,
    SRC_TRAP   = 2'd3
  } redirect_src_t;

  localparam int IALIGN_C   = 2;
  localparam int IALIGN_NOC = 4;

  function automatic int ialign(input bit c_ext);
    return c_ext ? IALIGN_C : IALIGN_NOC;
  endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC selection for the PC sequencer.
// Priority: trap > jalr > branch > sequential.
// Ports:
//   pc           current fetch address
//   inst_len_16  instruction at pc is 16-bit (only matters when C_EXT=1)
//   br_taken/br_offset, jalr_valid/jalr_target, trap_valid/trap_vector : redirect sources
//   src          winning source (redirect_src_t encoding)
//   target       winning target address, or pc + step when no redirect is active
//   misaligned   a branch/jalr target violates instruction alignment
module pc_target_sel
  import pc_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit C_EXT = 1'b0
) (
  input  logic [XLEN-1:0] pc,
  input  logic            inst_len_16,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_offset,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic [1:0]      src,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ialign(C_EXT) - 1);

  logic [XLEN-1:0] step;

  // All additions wrap modulo 2^XLEN. Trap vectors are word-aligned by masking,
  // jalr targets lose bit0, so only branch/jalr can produce a misaligned target.
  always_comb begin
    step   = (C_EXT && inst_len_16) ? XLEN'(2) : XLEN'(4);
    src    = SRC_SEQ;
    target = pc + step;
    if (trap_valid) begin
      src    = SRC_TRAP;
      target = trap_vector & ~XLEN'(3);
    end else if (jalr_valid) begin
      src    = SRC_JALR;
      target = jalr_target & ~XLEN'(1);
    end else if (br_taken) begin
      src    = SRC_BRANCH;
      target = pc + br_offset;
    end
    misaligned = ((src == SRC_BRANCH) || (src == SRC_JALR)) && ((target & ALIGN_MASK) != '0);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the femtoRV32 fetch stage.
// Presents pc_out to instruction memory with a valid/ready handshake, selects the
// next PC by priority, supports stall/halt, holds redirects that arrive under
// back-pressure, and traps misaligned branch/jalr targets into MISWAIT.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   pc_en          global stall when 0 (redirects are still captured)
//   fetch_ready    imem accepts the request this cycle
//   fetch_valid    pc_out is a live fetch request
//   pc_out         current fetch address
//   inst_len_16    current instruction is 16-bit (C_EXT=1 only)
//   br_*, jalr_*, trap_*  redirect sources
//   halt_req       enter HALT after the current request is accepted
//   resume         leave HALT at the held pc_out
//   misalign_err   one-cycle pulse on a misaligned branch/jalr target
//   redirect_pend  a captured redirect is waiting to be applied
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter bit              C_EXT        = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_out,
  input  logic            inst_len_16,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_offset,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt_req,
  input  logic            resume,
  output logic            misalign_err,
  output logic            redirect_pend
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_q, pend_d;
  logic            pend_trap_q, pend_trap_d;
  logic            pend_mis_q, pend_mis_d;
  logic            mis_q, mis_d;

  logic [1:0]      sel_src;
  logic [XLEN-1:0] sel_tgt;
  logic            sel_mis;
  logic            accept;
  logic            event_active;
  logic            use_pend;
  logic [XLEN-1:0] apply_tgt;
  logic            apply_mis;

  pc_target_sel #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_sel (
    .pc          (pc_q),
    .inst_len_16 (inst_len_16),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .jalr_valid  (jalr_valid),
    .jalr_target (jalr_target),
    .trap_valid  (trap_valid),
    .trap_vector (trap_vector),
    .src         (sel_src),
    .target      (sel_tgt),
    .misaligned  (sel_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
      pend_trap_q <= 1'b0;
      pend_mis_q  <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_trap_q <= pend_trap_d;
      pend_mis_q  <= pend_mis_d;
      mis_q       <= mis_d;
    end
  end

  // A pending redirect is applied on accept unless a trap arrives in that same
  // cycle; traps always win. The misalignment flag travels with a captured
  // target so the fault is raised when that target would actually become pc.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_tgt_d   = pend_tgt_q;
    pend_trap_d  = pend_trap_q;
    pend_mis_d   = pend_mis_q;
    mis_d        = 1'b0;
    accept       = (state_q == FETCH) && fetch_ready && pc_en;
    event_active = (sel_src != SRC_SEQ);
    use_pend     = pend_q && !trap_valid;
    apply_tgt    = use_pend ? pend_tgt_q : sel_tgt;
    apply_mis    = use_pend ? pend_mis_q : sel_mis;

    case (state_q)
      BOOT: begin
        if (pc_en) state_d = FETCH;
      end
      FETCH: begin
        if (accept) begin
          pend_d = 1'b0;
          if (apply_mis) begin
            mis_d   = 1'b1;
            state_d = MISWAIT;
          end else begin
            pc_d = apply_tgt;
            if (halt_req) state_d = HALT;
          end
        end else if (event_active && (!pend_q || ((sel_src == SRC_TRAP) && !pend_trap_q))) begin
          pend_d      = 1'b1;
          pend_tgt_d  = sel_tgt;
          pend_trap_d = (sel_src == SRC_TRAP);
          pend_mis_d  = sel_mis;
        end
      end
      HALT: begin
        if (pc_en) begin
          if (trap_valid) begin
            pc_d    = sel_tgt;
            state_d = FETCH;
          end else if (resume) begin
            state_d = FETCH;
          end
        end
      end
      MISWAIT: begin
        if (pc_en && trap_valid) begin
          pc_d    = sel_tgt;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    fetch_valid = (state_q == FETCH);
  end

  assign pc_out        = pc_q;
  assign misalign_err  = mis_q;
  assign redirect_pend = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. Two instances share all inputs:
// dut0 with C_EXT=0 and dut1 with C_EXT=1, so alignment and step rules can be
// compared side by side.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        pc_en;
  logic        fetch_ready;
  logic        inst_len_16;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        jalr_valid;
  logic [31:0] jalr_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        halt_req;
  logic        resume;

  logic        fv0, me0, rp0;
  logic [31:0] pc0;
  logic        fv1, me1, rp1;
  logic [31:0] pc1;

  int errors;
  int checks;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .pc_en(pc_en), .fetch_ready(fetch_ready),
    .fetch_valid(fv0), .pc_out(pc0), .inst_len_16(inst_len_16),
    .br_taken(br_taken), .br_offset(br_offset), .jalr_valid(jalr_valid),
    .jalr_target(jalr_target), .trap_valid(trap_valid), .trap_vector(trap_vector),
    .halt_req(halt_req), .resume(resume), .misalign_err(me0), .redirect_pend(rp0)
  );

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .pc_en(pc_en), .fetch_ready(fetch_ready),
    .fetch_valid(fv1), .pc_out(pc1), .inst_len_16(inst_len_16),
    .br_taken(br_taken), .br_offset(br_offset), .jalr_valid(jalr_valid),
    .jalr_target(jalr_target), .trap_valid(trap_valid), .trap_vector(trap_vector),
    .halt_req(halt_req), .resume(resume), .misalign_err(me1), .redirect_pend(rp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_en       = 1'b1;
    fetch_ready = 1'b1;
    inst_len_16 = 1'b0;
    br_taken    = 1'b0;
    br_offset   = 32'h0;
    jalr_valid  = 1'b0;
    jalr_target = 32'h0;
    trap_valid  = 1'b0;
    trap_vector = 32'h0;
    halt_req    = 1'b0;
    resume      = 1'b0;
  endtask

  // Reset both instances, release, and step once into FETCH at pc 0.
  task automatic restart();
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // Jump both instances to a known pc with a single trap.
  task automatic jump_to(input logic [31:0] addr);
    trap_valid  = 1'b1;
    trap_vector = addr;
    tick();
    trap_valid  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    trap_valid  = 1'b1;
    trap_vector = 32'h80;
    halt_req    = 1'b1;
    rst         = 1'b1;
    repeat (3) tick();
    checks++; if (pc0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc0, 32'h0); end
    checks++; if (fv0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_valid: got %b expected 0", fv0); end
    checks++; if (me0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %b expected 0", me0); end
    checks++; if (rp0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pend: got %b expected 0", rp0); end
    idle_inputs();
    rst = 1'b0;
    tick();
    checks++; if (fv0 !== 1'b1) begin errors++; $display("[TB] FAIL boot_fetch_valid: got %b expected 1", fv0); end
    checks++; if (pc0 !== 32'h0) begin errors++; $display("[TB] FAIL boot_pc: got %h expected %h", pc0, 32'h0); end
    tick();
    checks++; if (pc0 !== 32'h4) begin errors++; $display("[TB] FAIL seq_pc1: got %h expected %h", pc0, 32'h4); end
    tick();
    checks++; if (pc0 !== 32'h8) begin errors++; $display("[TB] FAIL seq_pc2: got %h expected %h", pc0, 32'h8); end
  endtask

  task automatic test_branch_jalr();
    restart();
    jump_to(32'h10);
    checks++; if (pc0 !== 32'h10) begin errors++; $display("[TB] FAIL setup_pc10: got %h expected %h", pc0, 32'h10); end
    br_taken  = 1'b1;
    br_offset = 32'hFFFF_FFF8;
    tick();
    checks++; if (pc0 !== 32'h08) begin errors++; $display("[TB] FAIL branch_back: got %h expected %h", pc0, 32'h08); end
    jalr_valid  = 1'b1;
    jalr_target = 32'h41;
    tick();
    idle_inputs();
    checks++; if (pc0 !== 32'h40) begin errors++; $display("[TB] FAIL jalr_over_branch: got %h expected %h", pc0, 32'h40); end
    checks++; if (me0 !== 1'b0) begin errors++; $display("[TB] FAIL jalr_no_misalign: got %b expected 0", me0); end
  endtask

  task automatic test_backpressure();
    fetch_ready = 1'b0;
    jalr_valid  = 1'b1;
    jalr_target = 32'h200;
    tick();
    jalr_valid = 1'b0;
    checks++; if (rp0 !== 1'b1) begin errors++; $display("[TB] FAIL bp_pend_set: got %b expected 1", rp0); end
    checks++; if (pc0 !== 32'h40) begin errors++; $display("[TB] FAIL bp_pc_hold: got %h expected %h", pc0, 32'h40); end
    br_taken  = 1'b1;
    br_offset = 32'h100;
    tick();
    br_taken = 1'b0;
    tick();
    checks++; if (pc0 !== 32'h40) begin errors++; $display("[TB] FAIL bp_pc_hold3: got %h expected %h", pc0, 32'h40); end
    checks++; if (fv0 !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %b expected 1", fv0); end
    fetch_ready = 1'b1;
    br_taken    = 1'b1;
    br_offset   = 32'h40;
    tick();
    br_taken = 1'b0;
    checks++; if (pc0 !== 32'h200) begin errors++; $display("[TB] FAIL bp_apply: got %h expected %h", pc0, 32'h200); end
    checks++; if (rp0 !== 1'b0) begin errors++; $display("[TB] FAIL bp_pend_clear: got %b expected 0", rp0); end
    tick();
    checks++; if (pc0 !== 32'h204) begin errors++; $display("[TB] FAIL bp_seq_after: got %h expected %h", pc0, 32'h204); end
  endtask

  task automatic test_trap_overwrite();
    fetch_ready = 1'b0;
    jalr_valid  = 1'b1;
    jalr_target = 32'h300;
    tick();
    jalr_valid  = 1'b0;
    trap_valid  = 1'b1;
    trap_vector = 32'h900;
    tick();
    trap_valid  = 1'b0;
    fetch_ready = 1'b1;
    tick();
    checks++; if (pc0 !== 32'h900) begin errors++; $display("[TB] FAIL trap_overwrites_jalr: got %h expected %h", pc0, 32'h900); end
    fetch_ready = 1'b0;
    trap_valid  = 1'b1;
    trap_vector = 32'hA00;
    tick();
    trap_vector = 32'hB00;
    tick();
    trap_valid  = 1'b0;
    fetch_ready = 1'b1;
    tick();
    checks++; if (pc0 !== 32'hA00) begin errors++; $display("[TB] FAIL first_trap_kept: got %h expected %h", pc0, 32'hA00); end
  endtask

  task automatic test_stall();
    pc_en     = 1'b0;
    br_taken  = 1'b1;
    br_offset = 32'h20;
    tick();
    br_taken = 1'b0;
    checks++; if (rp0 !== 1'b1) begin errors++; $display("[TB] FAIL stall_capture: got %b expected 1", rp0); end
    tick();
    checks++; if (pc0 !== 32'hA00) begin errors++; $display("[TB] FAIL stall_pc_hold: got %h expected %h", pc0, 32'hA00); end
    checks++; if (fv0 !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid_hold: got %b expected 1", fv0); end
    pc_en = 1'b1;
    tick();
    checks++; if (pc0 !== 32'hA20) begin errors++; $display("[TB] FAIL stall_release: got %h expected %h", pc0, 32'hA20); end
  endtask

  task automatic test_misalign();
    jump_to(32'h100);
    br_taken  = 1'b1;
    br_offset = 32'h6;
    tick();
    br_taken = 1'b0;
    checks++; if (me0 !== 1'b1) begin errors++; $display("[TB] FAIL mis_pulse: got %b expected 1", me0); end
    checks++; if (pc0 !== 32'h100) begin errors++; $display("[TB] FAIL mis_pc_hold: got %h expected %h", pc0, 32'h100); end
    checks++; if (fv0 !== 1'b0) begin errors++; $display("[TB] FAIL mis_valid_low: got %b expected 0", fv0); end
    jalr_valid  = 1'b1;
    jalr_target = 32'h400;
    tick();
    jalr_valid = 1'b0;
    checks++; if (me0 !== 1'b0) begin errors++; $display("[TB] FAIL mis_pulse_end: got %b expected 0", me0); end
    checks++; if (pc0 !== 32'h100) begin errors++; $display("[TB] FAIL miswait_ignore_jalr: got %h expected %h", pc0, 32'h100); end
    jump_to(32'h803);
    checks++; if (pc0 !== 32'h800) begin errors++; $display("[TB] FAIL miswait_trap_exit: got %h expected %h", pc0, 32'h800); end
    checks++; if (fv0 !== 1'b1) begin errors++; $display("[TB] FAIL miswait_refetch: got %b expected 1", fv0); end
    tick();
    checks++; if (pc0 !== 32'h804) begin errors++; $display("[TB] FAIL miswait_seq: got %h expected %h", pc0, 32'h804); end
  endtask

  task automatic test_halt();
    jump_to(32'h20);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (pc0 !== 32'h24) begin errors++; $display("[TB] FAIL halt_advance: got %h expected %h", pc0, 32'h24); end
    checks++; if (fv0 !== 1'b0) begin errors++; $display("[TB] FAIL halt_valid_low: got %b expected 0", fv0); end
    tick();
    checks++; if (pc0 !== 32'h24) begin errors++; $display("[TB] FAIL halt_pc_hold: got %h expected %h", pc0, 32'h24); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if (fv0 !== 1'b1) begin errors++; $display("[TB] FAIL resume_valid: got %b expected 1", fv0); end
    checks++; if (pc0 !== 32'h24) begin errors++; $display("[TB] FAIL resume_pc: got %h expected %h", pc0, 32'h24); end
    tick();
    checks++; if (pc0 !== 32'h28) begin errors++; $display("[TB] FAIL resume_seq: got %h expected %h", pc0, 32'h28); end
    halt_req = 1'b1;
    tick();
    halt_req    = 1'b0;
    resume      = 1'b1;
    trap_valid  = 1'b1;
    trap_vector = 32'h600;
    tick();
    idle_inputs();
    checks++; if (pc0 !== 32'h600) begin errors++; $display("[TB] FAIL halt_trap_beats_resume: got %h expected %h", pc0, 32'h600); end
    checks++; if (fv0 !== 1'b1) begin errors++; $display("[TB] FAIL halt_trap_valid: got %b expected 1", fv0); end
  endtask

  task automatic test_c_ext();
    restart();
    jump_to(32'h24);
    inst_len_16 = 1'b1;
    tick();
    checks++; if (pc1 !== 32'h26) begin errors++; $display("[TB] FAIL cext_step2: got %h expected %h", pc1, 32'h26); end
    checks++; if (pc0 !== 32'h28) begin errors++; $display("[TB] FAIL nocext_ignores_len16: got %h expected %h", pc0, 32'h28); end
    inst_len_16 = 1'b0;
    tick();
    checks++; if (pc1 !== 32'h2A) begin errors++; $display("[TB] FAIL cext_step4: got %h expected %h", pc1, 32'h2A); end
    br_taken  = 1'b1;
    br_offset = 32'h6;
    tick();
    br_taken = 1'b0;
    checks++; if (pc1 !== 32'h30) begin errors++; $display("[TB] FAIL cext_branch6: got %h expected %h", pc1, 32'h30); end
    checks++; if (me1 !== 1'b0) begin errors++; $display("[TB] FAIL cext_no_misalign: got %b expected 0", me1); end
    checks++; if (me0 !== 1'b1) begin errors++; $display("[TB] FAIL nocext_misalign: got %b expected 1", me0); end
    checks++; if (pc0 !== 32'h2C) begin errors++; $display("[TB] FAIL nocext_mis_hold: got %h expected %h", pc0, 32'h2C); end
    jalr_valid  = 1'b1;
    jalr_target = 32'h41;
    tick();
    jalr_valid = 1'b0;
    checks++; if (pc1 !== 32'h40) begin errors++; $display("[TB] FAIL cext_jalr_bit0: got %h expected %h", pc1, 32'h40); end
  endtask

  task automatic test_wrap_and_reset();
    restart();
    jump_to(32'hFFFF_FFFF);
    checks++; if (pc0 !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL trap_mask: got %h expected %h", pc0, 32'hFFFF_FFFC); end
    tick();
    checks++; if (pc0 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_zero: got %h expected %h", pc0, 32'h0); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    checks++; if (fv0 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_halt: got %b expected 0", fv0); end
    checks++; if (pc0 !== 32'h4) begin errors++; $display("[TB] FAIL wrap_halt_pc: got %h expected %h", pc0, 32'h4); end
    rst    = 1'b1;
    resume = 1'b1;
    tick();
    rst    = 1'b0;
    resume = 1'b0;
    checks++; if (pc0 !== 32'h0) begin errors++; $display("[TB] FAIL halt_reset_pc: got %h expected %h", pc0, 32'h0); end
    checks++; if (fv0 !== 1'b0) begin errors++; $display("[TB] FAIL halt_reset_valid: got %b expected 0", fv0); end
    tick();
    checks++; if (fv0 !== 1'b1) begin errors++; $display("[TB] FAIL halt_reset_boot: got %b expected 1", fv0); end
    checks++; if (pc0 !== 32'h0) begin errors++; $display("[TB] FAIL halt_reset_first: got %h expected %h", pc0, 32'h0); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();
    $display("[TB] pc_sequencer directed tests start");
    test_reset();
    test_branch_jalr();
    test_backpressure();
    test_trap_overwrite();
    test_stall();
    test_misalign();
    test_halt();
    test_c_ext();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
